lr_sequencer: RTL and testbench

Controller that sequences one simple-linear-regression solve (y = b0 + b1·x) around the shared X/Y matrix-inverse unit. It accepts a sample stream and accumulates the XᵀX and XᵀY entries (n, Σx, Σxx, Σy, Σxy). It then forms the determinant and both coefficient numerators, and issues two jobs to the inverse unit over its start/finished handshake. It sits between the sample source and the inverse unit, and returns b0, b1 and a status code to the top level.

---
 rtl/lr_sequencer_if.sv | 26 ++
 rtl/lr_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_lr_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lr_sequencer_if.sv
// Sample-stream and inverse-unit job bus for lr_sequencer.
// master: the sequencer side (consumes samples, launches jobs).
// slave: the environment side (sample source plus inverse unit).
interface lr_sequencer_if #(
  parameter int DATA_W = 8
) ();
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_x;
  logic signed [DATA_W-1:0] s_y;
  logic                     inv_start;
  logic signed [31:0]       inv_x;
  logic signed [31:0]       inv_y;
  logic                     inv_finished;
  logic signed [31:0]       inv_result;

  modport master (
    input  s_valid, s_x, s_y, inv_finished, inv_result,
    output s_ready, inv_start, inv_x, inv_y
  );

  modport slave (
    output s_valid, s_x, s_y, inv_finished, inv_result,
    input  s_ready, inv_start, inv_x, inv_y
  );
endinterface

// File: rtl/lr_sequencer.sv
// lr_sequencer: accumulates n, Sx, Sxx, Sy, Sxy from a sample stream, forms
// det/num0/num1 at full precision, saturates them to 32 bits and runs two
// jobs (num0/det, num1/det) on the shared inverse unit to obtain b0 and b1.
// Optional build macro LR_TIMEOUT_EN adds a per-job watchdog of TIMEOUT
// cycles that ends the solve with status 3.
module lr_sequencer #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_samples,
  lr_sequencer_if.master     bus,
  output logic               busy,
  output logic               done,
  output logic signed [31:0] b0,
  output logic signed [31:0] b1,
  output logic [1:0]         status
);
  localparam int SW = DATA_W + CNT_W;      // Sx, Sy
  localparam int QW = 2 * DATA_W + CNT_W;  // Sxx, Sxy
  localparam int DW = QW + SW + 1;         // products and their differences

  typedef enum logic [3:0] {
    IDLE, ACCUM, PROD, NUM, ISSUE0, WAIT0, ISSUE1, WAIT1, DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]           r_n, r_cnt, w_cnt_nxt;
  logic signed [SW-1:0]       r_sx, r_sy;
  logic signed [QW-1:0]       r_sxx, r_sxy;
  logic signed [2*DATA_W-1:0] w_xx, w_xy;
  logic signed [DW-1:0]       w_n_e, w_sx_e, w_sy_e, w_sxx_e, w_sxy_e;
  logic signed [DW-1:0]       r_nsxx_p1, r_sx2_p1, r_sxxsy_p1;
  logic signed [DW-1:0]       r_sxsxy_p1, r_nsxy_p1, r_sxsy_p1;
  logic signed [DW-1:0]       w_det, w_num0, w_num1;
  logic signed [31:0]         r_num1, r_inv_x, r_inv_y, r_b0, r_b1;
  logic [1:0]                 r_status;
  logic                       w_start_ok, w_accept, w_fin, w_tmo_hit, w_any_ovf;
  logic                       w_s_ready, w_inv_start, w_done;

  // True when v does not fit in a signed 32-bit word.
  function automatic logic ovf32(input logic signed [DW-1:0] v);
    logic [DW-32:0] top;
    top = v[DW-1:31];
    return !((&top) || !(|top));
  endfunction

  // Clamp to the signed 32-bit range.
  function automatic logic signed [31:0] sat32(input logic signed [DW-1:0] v);
    if (ovf32(v)) return v[DW-1] ? 32'sh80000000 : 32'sh7FFFFFFF;
    return $signed(v[31:0]);
  endfunction

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_accept   = (r_state == ACCUM) && bus.s_valid;
  assign w_fin      = ((r_state == WAIT0) || (r_state == WAIT1)) && bus.inv_finished;
  assign w_cnt_nxt  = r_cnt + CNT_W'(1);

  assign w_xx = bus.s_x * bus.s_x;
  assign w_xy = bus.s_x * bus.s_y;

  assign w_n_e   = DW'($signed({1'b0, r_n}));
  assign w_sx_e  = DW'(r_sx);
  assign w_sy_e  = DW'(r_sy);
  assign w_sxx_e = DW'(r_sxx);
  assign w_sxy_e = DW'(r_sxy);

  assign w_det     = r_nsxx_p1 - r_sx2_p1;
  assign w_num0    = r_sxxsy_p1 - r_sxsxy_p1;
  assign w_num1    = r_nsxy_p1 - r_sxsy_p1;
  assign w_any_ovf = ovf32(w_det) || ovf32(w_num0) || ovf32(w_num1);

`ifdef LR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;

  // Watchdog: counts WAIT cycles of the current job, restarted by each ISSUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                       r_tmo <= '0;
    else if ((r_state == ISSUE0) || (r_state == ISSUE1)) r_tmo <= '0;
    else if ((r_state == WAIT0) || (r_state == WAIT1))   r_tmo <= r_tmo + TW'(1);
  end

  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));
`else
  // Watchdog not built: WAIT states wait for inv_finished indefinitely.
  assign w_tmo_hit = (TIMEOUT < 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_inv_start = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE:   if (start) w_state_nxt = (n_samples == '0) ? PROD : ACCUM;
      ACCUM: begin
        w_s_ready = 1'b1;
        if (bus.s_valid && (w_cnt_nxt == r_n)) w_state_nxt = PROD;
      end
      PROD:   w_state_nxt = NUM;
      NUM:    w_state_nxt = (w_det == '0) ? DONE : ISSUE0;
      ISSUE0: begin
        w_inv_start = 1'b1;
        w_state_nxt = WAIT0;
      end
      WAIT0: begin
        if (bus.inv_finished)  w_state_nxt = ISSUE1;
        else if (w_tmo_hit)    w_state_nxt = DONE;
      end
      ISSUE1: begin
        w_inv_start = 1'b1;
        w_state_nxt = WAIT1;
      end
      WAIT1:  if (bus.inv_finished || w_tmo_hit) w_state_nxt = DONE;
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.inv_start = w_inv_start;
  assign done          = w_done;
  assign busy          = (r_state != IDLE);

  // Latched sample count and accepted-sample counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_n   <= '0;
      r_cnt <= '0;
    end else if (w_start_ok) begin
      r_n   <= n_samples;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // ACCUM: running sums, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (w_start_ok) begin
      r_sx  <= '0;
      r_sy  <= '0;
      r_sxx <= '0;
      r_sxy <= '0;
    end else if (w_accept) begin
      r_sx  <= r_sx + SW'(bus.s_x);
      r_sy  <= r_sy + SW'(bus.s_y);
      r_sxx <= r_sxx + QW'(w_xx);
      r_sxy <= r_sxy + QW'(w_xy);
    end
  end

  // PROD -> NUM: full-precision cross products.
  always_ff @(posedge clk) begin
    if (r_state == PROD) begin
      r_nsxx_p1  <= w_n_e * w_sxx_e;
      r_sx2_p1   <= w_sx_e * w_sx_e;
      r_sxxsy_p1 <= w_sxx_e * w_sy_e;
      r_sxsxy_p1 <= w_sx_e * w_sxy_e;
      r_nsxy_p1  <= w_n_e * w_sxy_e;
      r_sxsy_p1  <= w_sx_e * w_sy_e;
    end
  end

  // NUM -> ISSUE1: second numerator parked until job 0 completes.
  always_ff @(posedge clk) begin
    if (r_state == NUM) r_num1 <= sat32(w_num1);
  end

  // Job operands, captured coefficients and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inv_x  <= '0;
      r_inv_y  <= '0;
      r_b0     <= '0;
      r_b1     <= '0;
      r_status <= 2'd0;
    end else if (w_start_ok) begin
      r_b0     <= '0;
      r_b1     <= '0;
      r_status <= 2'd0;
    end else if (r_state == NUM) begin
      r_inv_x <= sat32(w_num0);
      r_inv_y <= sat32(w_det);
      if (w_det == '0)    r_status <= 2'd1;
      else if (w_any_ovf) r_status <= 2'd2;
    end else if (w_fin && (r_state == WAIT0)) begin
      r_b0    <= bus.inv_result;
      r_inv_x <= r_num1;
    end else if (w_fin) begin
      r_b1 <= bus.inv_result;
    end else if (((r_state == WAIT0) || (r_state == WAIT1)) && w_tmo_hit) begin
      r_status <= 2'd3;
    end
  end

  assign bus.inv_x = r_inv_x;
  assign bus.inv_y = r_inv_y;
  assign b0        = r_b0;
  assign b1        = r_b1;
  assign status    = r_status;
endmodule

// File: tb/tb_lr_sequencer.sv
// Bench for lr_sequencer: table of directed solves with a dividing inverse-unit
// model, plus hand sequences for start-in-WAIT0, reset abort and watchdog.
module tb_lr_sequencer;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 1024;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic [CNT_W-1:0]   n_samples;
  logic               busy, done;
  logic signed [31:0] b0, b1;
  logic [1:0]         status;

  lr_sequencer_if #(.DATA_W(DATA_W)) bus ();

  lr_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .n_samples(n_samples),
    .bus(bus), .busy(busy), .done(done), .b0(b0), .b1(b1), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int              n;
    logic [3:0][7:0] xs;
    logic [3:0][7:0] ys;
    bit              alt;
    bit              gaps;
    int              njobs;
    int              j0x;
    int              j0y;
    int              j1x;
    int              j1y;
    int              eb0;
    int              eb1;
    int              est;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Edge bookkeeping (cycle numbers follow the "edge t / cycle t+1" reading).
  int cyc = 0, acc_edge = 0, st_edge = 0;
  // Inverse-unit model and output monitor state.
  int job_cnt = 0, stab_err = 0, rdy_cnt = 0, done_cnt = 0, done_cyc = 0;
  int is_cnt = 0, first_is = -1, fin_edge = 0, wait_n = 0;
  int cur_x = 0, cur_y = 0;
  int jx[2], jy[2];
  bit pend = 0, busy_q = 0;
  int resp_n = 2;
  int lat = 3;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] xs, input logic [31:0] ys,
                              input bit alt, input bit gaps, input int nj,
                              input int j0x, input int j0y, input int j1x, input int j1y,
                              input int eb0, input int eb1, input int est);
    vec_t v;
    v.n = n; v.xs = xs; v.ys = ys; v.alt = alt; v.gaps = gaps; v.njobs = nj;
    v.j0x = j0x; v.j0y = j0y; v.j1x = j1x; v.j1y = j1y;
    v.eb0 = eb0; v.eb1 = eb1; v.est = est;
    return v;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.s_valid && bus.s_ready) acc_edge <= cyc + 1;
    if (start && !busy) st_edge <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 0;
      busy_q = 0;
      bus.inv_finished = 1'b0;
      bus.inv_result = '0;
    end else begin
      if (busy && !busy_q) begin
        job_cnt = 0; stab_err = 0; rdy_cnt = 0; done_cnt = 0; is_cnt = 0; first_is = -1;
      end
      busy_q = busy;
      bus.inv_finished = 1'b0;
      if (bus.s_ready) rdy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc + 1;
      end
      if (pend) begin
        if (bus.inv_x !== cur_x || bus.inv_y !== cur_y) stab_err++;
        if (wait_n == 0) begin
          bus.inv_finished = 1'b1;
          bus.inv_result = (cur_y != 0) ? cur_x / cur_y : 0;
          fin_edge = cyc + 1;
          pend = 0;
        end else begin
          wait_n--;
        end
      end
      if (bus.inv_start) begin
        is_cnt++;
        if (first_is < 0) first_is = cyc + 1;
        cur_x = bus.inv_x;
        cur_y = bus.inv_y;
        if (job_cnt < 2) begin
          jx[job_cnt] = cur_x;
          jy[job_cnt] = cur_y;
        end
        job_cnt++;
        if (job_cnt <= resp_n) begin
          pend = 1;
          wait_n = lat;
        end
      end
    end
  end

  // mode 0: plain solve; 1: start pulsed in WAIT0; 2: reset asserted in WAIT1.
  task automatic run_vec(input vec_t v, input string tag, input int mode);
    int guard;
    @(negedge clk);
    start = 1'b1;
    n_samples = CNT_W'(v.n);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, " busy_rise"}, busy, 1);
    for (int i = 0; i < v.n; i++) begin
      if (v.gaps && ($urandom_range(0, 1) == 1)) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      if (v.alt) begin
        bus.s_x = (i % 2 == 0) ? -8'sd128 : 8'sd127;
        bus.s_y = 8'sd127;
      end else begin
        bus.s_x = v.xs[i];
        bus.s_y = v.ys[i];
      end
      bus.s_valid = 1'b1;
      guard = 0;
      while (!bus.s_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 20) begin
        chk({tag, " s_ready_wait"}, 0, 1);
        bus.s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;

    if (mode != 0) begin
      guard = 0;
      while (job_cnt < mode && guard < 100) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (guard >= 100) begin
        chk({tag, " job_wait"}, 0, 1);
        return;
      end
      @(negedge clk);
      if (mode == 1) begin
        start = 1'b1;
        n_samples = 8'd7;
        @(negedge clk);
        start = 1'b0;
      end else begin
        chk({tag, " b0_before_abort"}, b0, 1);
        reset_n = 1'b0;
        #1;
        chk({tag, " busy"}, busy, 0);
        chk({tag, " inv_start"}, bus.inv_start, 0);
        chk({tag, " b0"}, b0, 0);
        chk({tag, " b1"}, b1, 0);
        chk({tag, " status"}, status, 0);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
    end

    guard = 0;
    while (done_cnt == 0 && guard < 3000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 3000) begin
      chk({tag, " done_wait"}, 0, 1);
      return;
    end
    chk({tag, " status"}, status, v.est);
    chk({tag, " jobs"}, job_cnt, v.njobs);
    chk({tag, " inv_start_cycles"}, is_cnt, v.njobs);
    if (v.njobs >= 1) begin
      chk({tag, " job0_x"}, jx[0], v.j0x);
      chk({tag, " job0_y"}, jy[0], v.j0y);
      chk({tag, " inv_start_t+3"}, first_is, acc_edge + 3);
    end
    if (v.njobs == 2) begin
      chk({tag, " job1_x"}, jx[1], v.j1x);
      chk({tag, " job1_y"}, jy[1], v.j1y);
      chk({tag, " b0"}, b0, v.eb0);
      chk({tag, " b1"}, b1, v.eb1);
      chk({tag, " done_f+1"}, done_cyc, fin_edge + 1);
      chk({tag, " operand_hold"}, stab_err, 0);
    end
    if (v.njobs == 0) chk({tag, " done_t+3"}, done_cyc, ((v.n > 0) ? acc_edge : st_edge) + 3);
    if (v.est == 3) chk({tag, " done_timeout"}, done_cyc, first_is + TIMEOUT + 1);
    if (!v.gaps) chk({tag, " s_ready_cycles"}, rdy_cnt, v.n);
    @(negedge clk);
    #1;
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " busy_fall"}, busy, 0);
    chk({tag, " done_count"}, done_cnt, 1);
  endtask

  vec_t vecs[7];

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    n_samples = '0;
    bus.s_valid = 1'b0;
    bus.s_x = '0;
    bus.s_y = '0;

    vecs[0] = mk(4, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd7, 8'd5, 8'd3, 8'd1}, 0, 0,
                 2, 20, 20, 40, 20, 1, 2, 0);
    vecs[1] = mk(4, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd7, 8'd5, 8'd3, 8'd1}, 0, 1,
                 2, 20, 20, 40, 20, 1, 2, 0);
    vecs[2] = mk(3, {8'd0, 8'd5, 8'd5, 8'd5}, {8'd0, 8'd3, 8'd2, 8'd1}, 0, 0,
                 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[3] = mk(0, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vecs[4] = mk(255, 32'd0, 32'd0, 1, 0,
                 2, 32'h7FFFFFFF, 1057046400, 0, 1057046400, 2, 0, 2);
    vecs[5] = mk(2, {8'd0, 8'd0, 8'hFF, 8'd1}, {8'd0, 8'd0, 8'd5, 8'hFD}, 0, 0,
                 2, 4, 4, -16, 4, 1, -4, 0);
    vecs[6] = mk(4, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd7, 8'd5, 8'd3, 8'd1}, 0, 0,
                 1, 20, 20, 0, 0, 0, 0, 3);

    repeat (3) @(negedge clk);
    #1;
    chk("reset s_ready", bus.s_ready, 0);
    chk("reset inv_start", bus.inv_start, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset inv_x", bus.inv_x, 0);
    chk("reset inv_y", bus.inv_y, 0);
    chk("reset b0", b0, 0);
    chk("reset b1", b1, 0);
    chk("reset status", status, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k), 0);

    run_vec(vecs[0], "start_in_wait0", 1);
    resp_n = 1;
    run_vec(vecs[0], "abort_wait1", 2);
    resp_n = 2;
    run_vec(vecs[5], "after_abort", 0);
`ifdef LR_TIMEOUT_EN
    resp_n = 0;
    run_vec(vecs[6], "timeout", 0);
    resp_n = 2;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
